// File: rtl/seq_serializer_if.sv
// Load/serial-output bundle between an upstream word source and the serializer.
// Latency: none, wires only.
// Backpressure: load_valid/load_ready handshake on the load side; hold stalls the serial side.
//
// Signals
//   load_valid / load_ready  word offer and acceptance
//   load_data / load_len     word to send and its bit count (clamped to WIDTH inside)
//   hold                     consumer stall request
//   x / x_valid              serial bit and its qualifier
//   busy / done / bits_left  status: word in flight, end-of-word pulse, bits still to present
interface seq_serializer_if #(
    parameter int WIDTH = 64
);
    localparam int LW = $clog2(WIDTH) + 1;

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LW-1:0]    load_len;
    logic             hold;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic [LW-1:0]    bits_left;

    // master: the word source / serial consumer side
    modport master (
        output load_valid, load_data, load_len, hold,
        input  load_ready, x, x_valid, busy, done, bits_left
    );

    // slave: the serializer itself
    modport slave (
        input  load_valid, load_data, load_len, hold,
        output load_ready, x, x_valid, busy, done, bits_left
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial shifter feeding a sequence detector, MSB of the effective length first.
// Latency: first bit on x one cycle after the load edge; done pulses the cycle after the last bit.
// Backpressure: load_ready only in IDLE; hold freezes shifting and drops x_valid for that cycle.
//
// Ports
//   clk, rst  clock and synchronous active-high reset
//   bus       seq_serializer_if.slave: load handshake in, serial bit and status out
module seq_serializer #(
    parameter int   WIDTH      = 64,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    seq_serializer_if.slave bus
);
    localparam int LW = $clog2(WIDTH) + 1;
    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;      // word left-aligned; current bit is always the MSB
    logic [LW-1:0]    cnt;        // bits not yet presented
    logic             x_q;        // value x showed last cycle, replayed while held
    logic [LW-1:0]    eff_len;
    logic             load_fire;
    logic             shift_en;
    logic             x_out;
    logic             x_vld_out;

    // Lengths beyond the register width are clamped rather than wrapped.
    always_comb begin
        eff_len = (bus.load_len > WIDTH_L) ? WIDTH_L : bus.load_len;
    end

    assign load_fire = (state == IDLE) && bus.load_valid;
    assign shift_en  = (state == SHIFT) && !bus.hold;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_fire) begin
                    // A zero-length word still produces its done pulse.
                    state_nxt = (eff_len == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en && (cnt == LW'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift register and bit counter. Loading left-aligns the word so that
    // bit L-1 sits at the MSB; an L of zero shifts everything out.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            x_q   <= IDLE_LEVEL;
        end else begin
            x_q <= x_out;
            if (load_fire) begin
                shreg <= bus.load_data << (WIDTH_L - eff_len);
                cnt   <= eff_len;
            end else if (shift_en) begin
                shreg <= shreg << 1;
                cnt   <= cnt - LW'(1);
            end
        end
    end

    // Serial output: decoded from state and registers only, so nothing on
    // the load side reaches x combinationally. hold gates x_valid in the
    // same cycle and makes x repeat what it last showed.
    always_comb begin
        x_out     = IDLE_LEVEL;
        x_vld_out = 1'b0;
        if (state == SHIFT) begin
            if (bus.hold) begin
                x_out = x_q;
            end else begin
                x_out     = shreg[WIDTH-1];
                x_vld_out = 1'b1;
            end
        end
    end

    assign bus.x          = x_out;
    assign bus.x_valid    = x_vld_out;
    assign bus.load_ready = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.bits_left  = cnt;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: directed word scenarios plus randomized traffic,
// all checked against a bit-queue model of the serial stream.
module tb_seq_serializer;
    localparam int   WIDTH    = 64;
    localparam int   LW       = $clog2(WIDTH) + 1;
    localparam logic IDLE_LVL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_serializer_if #(.WIDTH(WIDTH)) bus ();

    seq_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LVL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: the bits still owed for the word in flight, whether a done
    // cycle is owed, and what x last showed.
    bit   mq[$];
    bit   m_done   = 1'b0;
    logic m_lastx  = IDLE_LVL;
    bit   model_on = 1'b0;

    // Downstream 001/110 detector fed by valid serial bits
    logic [2:0] det_hist = '0;
    int         det_n    = 0;
    int         det_y    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Called once per cycle at the falling edge: compare outputs with the
    // model, feed the detector, then advance the model by the inputs that
    // the coming rising edge will see.
    task automatic model_step();
        logic          e_rdy, e_x, e_xv, e_busy, e_done;
        logic [LW-1:0] e_bl;
        logic [12:0]   got, exp;
        int            len;
        if (mq.size() > 0) begin
            e_rdy = 1'b0; e_busy = 1'b1; e_done = 1'b0; e_bl = LW'(mq.size());
            if (bus.hold) begin e_xv = 1'b0; e_x = m_lastx; end
            else          begin e_xv = 1'b1; e_x = mq[0];   end
        end else if (m_done) begin
            e_rdy = 1'b0; e_busy = 1'b1; e_done = 1'b1; e_bl = '0; e_xv = 1'b0; e_x = IDLE_LVL;
        end else begin
            e_rdy = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_bl = '0; e_xv = 1'b0; e_x = IDLE_LVL;
        end
        if (model_on) begin
            got = {bus.load_ready, bus.x, bus.x_valid, bus.busy, bus.done, 1'b0, bus.bits_left};
            exp = {e_rdy, e_x, e_xv, e_busy, e_done, 1'b0, e_bl};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got rdy,x,xv,busy,done,bl=%b,%b,%b,%b,%b,%0d exp=%b,%b,%b,%b,%b,%0d",
                         $time, bus.load_ready, bus.x, bus.x_valid, bus.busy, bus.done, bus.bits_left,
                         e_rdy, e_x, e_xv, e_busy, e_done, e_bl);
            end
        end
        if (bus.x_valid === 1'b1) begin
            det_hist = {det_hist[1:0], bus.x};
            det_n++;
            if (det_n >= 3 && (det_hist == 3'b001 || det_hist == 3'b110)) det_y++;
        end
        m_lastx = e_x;
        if (rst) begin
            mq.delete();
            m_done  = 1'b0;
            m_lastx = IDLE_LVL;
        end else if (mq.size() > 0) begin
            if (!bus.hold) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (bus.load_valid) begin
            len = (int'(bus.load_len) > WIDTH) ? WIDTH : int'(bus.load_len);
            for (int i = len - 1; i >= 0; i--) mq.push_back(bus.load_data[i]);
            if (len == 0) m_done = 1'b1;
        end
    endtask

    // One cycle: check at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (bus.load_ready === 1'b1) return;
            tick();
        end
        chk("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    // Present a word for exactly one cycle; returns in cycle +1.
    task automatic load_word(input logic [63:0] d, input int len);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        bus.load_len   = LW'(len);
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic long_word(input int len);
        int ones, nv;
        ones = 0; nv = 0;
        wait_idle();
        load_word(64'hFFFF_FFFF_FFFF_FFFE, len);
        for (int k = 1; k <= 65; k++) begin
            #2;
            if (k == 1) chk("long_bl_first", 64'(bus.bits_left), 64'd64);
            if (k <= 64) begin
                if (bus.x_valid === 1'b1) begin nv++; if (bus.x === 1'b1) ones++; end
                if (k == 64) chk("long_last_bit", 64'(bus.x), 64'd0);
            end else begin
                chk("long_done", 64'(bus.done), 64'd1);
                chk("long_bl_end", 64'(bus.bits_left), 64'd0);
            end
            tick();
        end
        chk("long_ones", 64'(ones), 64'd63);
        chk("long_nvalid", 64'(nv), 64'd64);
    endtask

    initial begin
        logic [2:0] p3;
        logic [4:0] got5;
        int         nv5;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_len   = '0;
        bus.hold       = 1'b0;

        // Reset
        rst = 1'b1;
        tick();
        model_on = 1'b1;
        chk("rst_ready", 64'(bus.load_ready), 64'd1);
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_xv",    64'(bus.x_valid), 64'd0);
        chk("rst_done",  64'(bus.done), 64'd0);
        chk("rst_bl",    64'(bus.bits_left), 64'd0);
        chk("rst_x",     64'(bus.x), 64'(IDLE_LVL));
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 64'(bus.load_ready), 64'd1);

        // 3-bit word 001
        wait_idle();
        p3 = 3'b001;
        bus.load_valid = 1'b1; bus.load_data = 64'(p3); bus.load_len = LW'(3);
        #2;
        chk("w3_ready", 64'(bus.load_ready), 64'd1);
        tick();
        bus.load_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #2;
            if (k <= 3) begin
                chk("w3_xv", 64'(bus.x_valid), 64'd1);
                chk("w3_x",  64'(bus.x), 64'(p3[3-k]));
            end else if (k == 4) begin
                chk("w3_done", 64'(bus.done), 64'd1);
                chk("w3_done_xv", 64'(bus.x_valid), 64'd0);
            end else begin
                chk("w3_idle_ready", 64'(bus.load_ready), 64'd1);
                chk("w3_idle_busy", 64'(bus.busy), 64'd0);
            end
            tick();
        end

        // Full-width word, then an over-length request clamped to 64
        long_word(64);
        long_word(100);

        // 5-bit word 10110 with a two-cycle stall
        wait_idle();
        load_word(64'b10110, 5);
        got5 = '0; nv5 = 0;
        for (int k = 1; k <= 8; k++) begin
            bus.hold = (k == 2 || k == 3);
            #2;
            if (bus.hold) begin
                chk("hold_xv", 64'(bus.x_valid), 64'd0);
                chk("hold_x_frozen", 64'(bus.x), 64'd1);
                chk("hold_bl", 64'(bus.bits_left), 64'd4);
            end else if (k <= 7) begin
                if (bus.x_valid === 1'b1) begin got5 = {got5[3:0], bus.x}; nv5++; end
            end else begin
                chk("hold_done", 64'(bus.done), 64'd1);
            end
            tick();
        end
        bus.hold = 1'b0;
        chk("hold_bits", 64'(got5), 64'b10110);
        chk("hold_nbits", 64'(nv5), 64'd5);

        // Zero-length word with load_valid held high into the next word
        wait_idle();
        bus.load_valid = 1'b1; bus.load_data = 64'b101; bus.load_len = '0;
        tick();
        bus.load_len = LW'(3);
        #2;
        chk("len0_done", 64'(bus.done), 64'd1);
        chk("len0_xv", 64'(bus.x_valid), 64'd0);
        chk("len0_ready", 64'(bus.load_ready), 64'd0);
        tick();
        #2;
        chk("len0_next_ready", 64'(bus.load_ready), 64'd1);
        tick();
        bus.load_valid = 1'b0;
        #2;
        chk("len0_next_x", 64'(bus.x), 64'd1);
        chk("len0_next_bl", 64'(bus.bits_left), 64'd3);

        // Reset in the middle of a 10-bit word
        wait_idle();
        load_word(64'h2A5, 10);
        for (int k = 1; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        #2;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_bl", 64'(bus.bits_left), 64'd0);
        chk("mid_rst_xv", 64'(bus.x_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("mid_rst_ready", 64'(bus.load_ready), 64'd1);
        for (int k = 0; k < 12; k++) begin
            chk("mid_rst_no_done", 64'(bus.done), 64'd0);
            tick();
        end

        // Detector-fed word 001110
        wait_idle();
        det_hist = '0; det_n = 0; det_y = 0;
        load_word(64'b001110, 6);
        for (int k = 0; k < 8; k++) tick();
        chk("det_pulses", 64'(det_y), 64'd2);
        chk("det_nbits", 64'(det_n), 64'd6);

        // Randomized traffic: loads during busy, stalls, over-length, resets
        for (int n = 0; n < 4000; n++) begin
            bus.load_valid = ($urandom_range(0, 2) == 0);
            bus.load_data  = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) bus.load_len = LW'($urandom_range(60, 127));
            else                           bus.load_len = LW'($urandom_range(0, 12));
            bus.hold = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0;
        bus.load_valid = 1'b0;
        bus.hold = 1'b0;
        for (int k = 0; k < 80; k++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
